// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus multi-step shift/rotate sequencer.
// Optional USR_PARITY_EN macro adds a combinational even-parity output of Q.
module universal_shift_register #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         mode,
  input  logic               sin,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   Q,
  output logic               sout,
  output logic               busy,
  output logic               done
`ifdef USR_PARITY_EN
  ,
  output logic               parity
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [1:0]         mode_r;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   q_next;

  // One step of the latched operation; mode 00 is a valid no-op step.
  always_comb begin
    q_next = Q;
    case (mode_r)
      2'b01:   q_next = {sin, Q[WIDTH-1:1]};
      2'b10:   q_next = {Q[WIDTH-2:0], sin};
      2'b11:   q_next = {Q[0], Q[WIDTH-1:1]};
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q      <= '0;
      mode_r <= 2'b00;
      count  <= '0;
      state  <= IDLE;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            Q <= B;
          end else if (start) begin
            if (shamt == '0) begin
              done <= 1'b1;
            end else begin
              mode_r <= mode;
              count  <= shamt;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          Q     <= q_next;
          count <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

  // Reset clears both Q and mode_r, so sout is 0 under reset without extra gating.
  always_comb begin
    case (mode_r)
      2'b01, 2'b11: sout = Q[0];
      2'b10:        sout = Q[WIDTH-1];
      default:      sout = 1'b0;
    endcase
  end

`ifdef USR_PARITY_EN
  assign parity = ^Q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized and directed bench for universal_shift_register against a cycle-level behavioural model.
// Parity checks are included when USR_PARITY_EN is defined.
module tb_universal_shift_register;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               load;
  logic [WIDTH-1:0]   B;
  logic [1:0]         mode;
  logic               sin;
  logic               start;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   Q;
  logic               sout;
  logic               busy;
  logic               done;
`ifdef USR_PARITY_EN
  logic               parity;
`endif

  universal_shift_register #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .B(B), .mode(mode), .sin(sin),
    .start(start), .shamt(shamt), .Q(Q), .sout(sout), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: register value, pending step count and the latched operation.
  int         m_q;
  int         m_mode;
  int         m_left;
  bit         m_done;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int stepValue(input int q, input int md, input int s);
    case (md)
      1:       return (q >> 1) + (s * 128);
      2:       return ((q * 2) % 256) + s;
      3:       return (q >> 1) + ((q % 2) * 128);
      default: return q;
    endcase
  endfunction

  function automatic int expectedSout(input int q, input int md);
    if (md == 1 || md == 3) return q % 2;
    if (md == 2)            return q / 128;
    return 0;
  endfunction

  task automatic modelReset();
    m_q = 0; m_mode = 0; m_left = 0; m_done = 0;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".Q"},    32'(Q),    32'(m_q));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(m_left != 0));
    checkOutput({tag, ".done"}, 32'(done), 32'(m_done));
    checkOutput({tag, ".sout"}, 32'(sout), 32'(expectedSout(m_q, m_mode)));
`ifdef USR_PARITY_EN
    checkOutput({tag, ".parity"}, 32'(parity), 32'($countones(m_q[7:0]) % 2));
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare just after it.
  task automatic applyStimulus(input string tag, input logic ld, input logic [7:0] b, input logic [1:0] md,
                               input logic s, input logic st, input logic [3:0] sh);
    @(negedge clk);
    load = ld; B = b; mode = md; sin = s; start = st; shamt = sh;
    @(posedge clk);
    m_done = 0;
    if (m_left == 0) begin
      if (ld) m_q = int'(b);
      else if (st) begin
        if (sh == 0) m_done = 1;
        else begin
          m_mode = int'(md);
          m_left = int'(sh);
        end
      end
    end else begin
      m_q = stepValue(m_q, m_mode, int'(s));
      m_left--;
      if (m_left == 0) m_done = 1;
    end
    #1;
    compareAll(tag);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear before the next edge.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".Q"},    32'(Q),    32'h0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
    checkOutput({tag, ".done"}, 32'(done), 32'h0);
    checkOutput({tag, ".sout"}, 32'(sout), 32'h0);
`ifdef USR_PARITY_EN
    checkOutput({tag, ".parity"}, 32'(parity), 32'h0);
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int busyCount;
    int doneCount;
    reset_n = 1'b0; load = 0; B = 0; mode = 0; sin = 0; start = 0; shamt = 0;
    modelReset();
    #2;
    checkOutput("rst0.Q", 32'(Q), 32'h0);
    checkOutput("rst0.busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load wins over a simultaneous start.
    applyStimulus("load", 1'b1, 8'hA5, 2'b01, 1'b0, 1'b1, 4'd3);
    checkOutput("load.Q_A5", 32'(Q), 32'hA5);
    checkOutput("load.busy0", 32'(busy), 32'h0);
`ifdef USR_PARITY_EN
    checkOutput("parity_A5", 32'(parity), 32'h0);
`endif

    // Shift right by 3 with sin=0.
    busyCount = 0; doneCount = 0;
    applyStimulus("sr.start", 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 4'd3);
    busyCount += int'(busy);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sr.step", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
      busyCount += int'(busy);
      doneCount += int'(done);
      if (i == 2) checkOutput("sr.Q_14", 32'(Q), 32'h14);
    end
    checkOutput("sr.busy_cycles", 32'(busyCount), 32'd3);
    checkOutput("sr.done_pulses", 32'(doneCount), 32'd1);

    // Rotate right by 4, with a load attempt ignored while busy.
    applyStimulus("rot.load", 1'b1, 8'hA5, 2'b00, 1'b0, 1'b0, 4'd0);
    applyStimulus("rot.start", 1'b0, 8'h00, 2'b11, 1'b0, 1'b1, 4'd4);
    applyStimulus("rot.ldbusy", 1'b1, 8'hFF, 2'b00, 1'b1, 1'b1, 4'd2);
    idleCycles("rot.step", 3);
    checkOutput("rot.Q_5A", 32'(Q), 32'h5A);

    // Shift left by 2 with sin=1.
    applyStimulus("sl.load", 1'b1, 8'h81, 2'b00, 1'b0, 1'b0, 4'd0);
    applyStimulus("sl.start", 1'b0, 8'h00, 2'b10, 1'b1, 1'b1, 4'd2);
    applyStimulus("sl.step1", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 4'd0);
    applyStimulus("sl.step2", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 4'd0);
    checkOutput("sl.Q_07", 32'(Q), 32'h07);
`ifdef USR_PARITY_EN
    checkOutput("parity_07", 32'(parity), 32'h1);
`endif

    // Zero shift amount: immediate done, no state change.
    applyStimulus("zero.start", 1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 4'd0);
    checkOutput("zero.done", 32'(done), 32'h1);
    checkOutput("zero.Q", 32'(Q), 32'h07);
    idleCycles("zero.after", 1);

    // Reset during step 2 of a 5-step shift aborts without a done pulse.
    applyStimulus("abort.load", 1'b1, 8'hA5, 2'b00, 1'b0, 1'b0, 4'd0);
    applyStimulus("abort.start", 1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 4'd5);
    applyStimulus("abort.step1", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 4'd0);
    pulseReset("abort.rst");
    idleCycles("abort.after", 6);
    applyStimulus("abort.reload", 1'b1, 8'h3C, 2'b00, 1'b0, 1'b0, 4'd0);

    // Shift amount beyond WIDTH runs every step.
    applyStimulus("long.start", 1'b0, 8'h00, 2'b11, 1'b0, 1'b1, 4'd13);
    idleCycles("long.step", 14);

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) pulseReset("rand.rst");
      applyStimulus("rand", ($urandom_range(0, 5) == 0), 8'($urandom), 2'($urandom),
                    1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
